// File: rtl/vend_uart_pkg.sv
// Shared definitions for the vending-machine UART link: ASCII constants,
// parser state encoding and error codes.
package vend_uart_pkg;

  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUND,
    ST_TENS,
    ST_ONES,
    ST_TERM
  } parse_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BADCHAR  = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_code_e;

endpackage

// File: rtl/rx_parse.sv
// Receive-side command parser: assembles "<sign><d><d><d><CR|LF>" lines into
// signed 3-digit BCD commands on a valid/ready handshake, with error strobes.
module rx_parse
  import vend_uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_sign,
  output logic [11:0] cmd_bcd,
  output logic        err_pulse,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  parse_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_w_q, sign_w_d;
  logic [11:0]      bcd_w_q, bcd_w_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             cmd_sign_q, cmd_sign_d;
  logic [11:0]      cmd_bcd_q, cmd_bcd_d;
  logic             err_pulse_q, err_pulse_d;
  err_code_e        err_code_q, err_code_d;

  logic      is_digit;
  logic      is_term;
  logic      commit;
  err_code_e err;

  assign is_digit = (rx_byte >= ASCII_0) && (rx_byte <= ASCII_9);
  assign is_term  = (rx_byte == ASCII_CR) || (rx_byte == ASCII_LF);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sign_w_d    = sign_w_q;
    bcd_w_d     = bcd_w_q;
    cmd_valid_d = cmd_valid_q;
    cmd_sign_d  = cmd_sign_q;
    cmd_bcd_d   = cmd_bcd_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    commit      = 1'b0;
    err         = ERR_NONE;

    if (rx_dv) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_byte == ASCII_PLUS || rx_byte == ASCII_MINUS) begin
            sign_w_d = (rx_byte == ASCII_MINUS);
            state_d  = ST_HUND;
          end else if (!(is_term || rx_byte == ASCII_SPACE)) begin
            err = ERR_BADCHAR;
          end
        end
        ST_HUND, ST_TENS, ST_ONES: begin
          if (is_digit) begin
            // Digits 0x30..0x39 map to BCD through their low nibble.
            unique case (state_q)
              ST_HUND: begin bcd_w_d[11:8] = rx_byte[3:0]; state_d = ST_TENS; end
              ST_TENS: begin bcd_w_d[7:4]  = rx_byte[3:0]; state_d = ST_ONES; end
              default: begin bcd_w_d[3:0]  = rx_byte[3:0]; state_d = ST_TERM; end
            endcase
          end else begin
            err     = ERR_BADCHAR;
            state_d = ST_IDLE;
          end
        end
        ST_TERM: begin
          state_d = ST_IDLE;
          if (is_term) commit = 1'b1;
          else         err    = ERR_BADCHAR;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && cnt_q == CNT_LAST) begin
      err     = ERR_TIMEOUT;
      state_d = ST_IDLE;
    end

    if (rx_dv || state_q == ST_IDLE || err == ERR_TIMEOUT) cnt_d = '0;
    else                                                    cnt_d = cnt_q + CNT_W'(1);

    if (cmd_valid_q && cmd_ready) cmd_valid_d = 1'b0;

    // A slot being accepted this cycle counts as free, so back-to-back commits don't overflow.
    if (commit) begin
      if (!cmd_valid_q || cmd_ready) begin
        cmd_valid_d = 1'b1;
        cmd_sign_d  = sign_w_q;
        cmd_bcd_d   = bcd_w_d;
      end else begin
        err = ERR_OVERFLOW;
      end
    end

    if (err != ERR_NONE) begin
      err_pulse_d = 1'b1;
      err_code_d  = err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sign_w_q    <= 1'b0;
      bcd_w_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_sign_q  <= 1'b0;
      cmd_bcd_q   <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sign_w_q    <= sign_w_d;
      bcd_w_q     <= bcd_w_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_sign_q  <= cmd_sign_d;
      cmd_bcd_q   <= cmd_bcd_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_sign  = cmd_sign_q;
  assign cmd_bcd   = cmd_bcd_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_parse.sv
// Bench for rx_parse: line-buffer reference model checked every cycle, plus
// hand-computed output snapshots at key points of directed byte sequences.
module tb_rx_parse;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        cmd_sign;
  logic [11:0] cmd_bcd;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic        busy;

  rx_parse #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_dv     (rx_dv),
    .rx_byte   (rx_byte),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sign  (cmd_sign),
    .cmd_bcd   (cmd_bcd),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the line so far is a byte queue; outputs follow from its contents.
  byte unsigned line[$];
  int           idle_cycles = 0;
  bit           m_valid = 0, m_sign = 0, m_pulse = 0, m_busy = 0;
  int           m_bcd = 0, m_code = 0;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        line.delete();
        idle_cycles = 0;
        m_valid = 0; m_sign = 0; m_bcd = 0; m_pulse = 0; m_code = 0; m_busy = 0;
      end else begin
        bit free, do_commit;
        int e, val;
        free      = !m_valid || cmd_ready;
        do_commit = 0;
        e         = 0;
        if (m_valid && cmd_ready) m_valid = 0;
        if (rx_dv) begin
          idle_cycles = 0;
          if (line.size() == 0) begin
            if (rx_byte == "+" || rx_byte == "-") line.push_back(rx_byte);
            else if (!(rx_byte == 8'h0D || rx_byte == 8'h0A || rx_byte == " ")) e = 1;
          end else if (line.size() < 4) begin
            if (rx_byte >= "0" && rx_byte <= "9") line.push_back(rx_byte);
            else begin e = 1; line.delete(); end
          end else begin
            if (rx_byte == 8'h0D || rx_byte == 8'h0A) do_commit = 1;
            else begin e = 1; line.delete(); end
          end
        end else if (line.size() > 0) begin
          idle_cycles++;
          if (idle_cycles == T) begin e = 3; line.delete(); idle_cycles = 0; end
        end
        if (do_commit) begin
          val = (int'(line[1]) - 48) * 100 + (int'(line[2]) - 48) * 10 + (int'(line[3]) - 48);
          if (free) begin
            m_valid = 1;
            m_sign  = (line[0] == "-");
            m_bcd   = (val / 100) * 256 + ((val / 10) % 10) * 16 + (val % 10);
          end else e = 2;
          line.delete();
        end
        m_pulse = (e != 0);
        if (e != 0) m_code = e;
        m_busy = (line.size() > 0);
      end
    end
  end

  // Hand-computed snapshot requests from the stimulus thread.
  int    pin_seq = 0;
  string pin_name;
  int    pin_v, pin_s, pin_bcd, pin_ep, pin_ec, pin_busy;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  initial begin
    int last_seq = 0;
    forever begin
      @(negedge clk);
      chk("cmd_valid", int'(cmd_valid), int'(m_valid));
      chk("cmd_sign",  int'(cmd_sign),  int'(m_sign));
      chk("cmd_bcd",   int'(cmd_bcd),   m_bcd);
      chk("err_pulse", int'(err_pulse), int'(m_pulse));
      chk("err_code",  int'(err_code),  m_code);
      chk("busy",      int'(busy),      int'(m_busy));
      if (pin_seq != last_seq) begin
        last_seq = pin_seq;
        checks++;
        if (int'(cmd_valid) != pin_v || int'(cmd_sign) != pin_s || int'(cmd_bcd) != pin_bcd ||
            int'(err_pulse) != pin_ep || int'(err_code) != pin_ec || int'(busy) != pin_busy) begin
          errors++;
          $display("FAIL %s: got v=%0d s=%0d bcd=%03h ep=%0d ec=%0d busy=%0d expected v=%0d s=%0d bcd=%03h ep=%0d ec=%0d busy=%0d",
                   pin_name, cmd_valid, cmd_sign, cmd_bcd, err_pulse, err_code, busy,
                   pin_v, pin_s, pin_bcd, pin_ep, pin_ec, pin_busy);
        end
      end
    end
  end

  task automatic pin(input string nm, input int v, input int s, input int bcd,
                     input int ep, input int ec, input int b);
    pin_name = nm; pin_v = v; pin_s = s; pin_bcd = bcd;
    pin_ep = ep; pin_ec = ec; pin_busy = b;
    pin_seq++;
    @(negedge clk);
  endtask

  task automatic send_byte(input byte unsigned b);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    rx_dv   = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    pin("reset_state", 0, 0, 12'h000, 0, 0, 0);
    #1 reset = 1'b0;

    cmd_ready = 1'b1;
    send_str("+123\r");
    pin("plus123_valid", 1, 0, 12'h123, 0, 0, 0);
    pin("plus123_drop", 0, 0, 12'h123, 0, 0, 0);

    cmd_ready = 1'b0;
    send_str("-050\r\n");
    pin("minus050_held", 1, 1, 12'h050, 0, 0, 0);
    send_str("+999\n");
    pin("overflow", 1, 1, 12'h050, 1, 2, 0);
    cmd_ready = 1'b1;
    pin("minus050_accepted", 0, 1, 12'h050, 0, 2, 0);

    send_str("+1A");
    pin("badchar_A", 0, 1, 12'h050, 1, 1, 0);
    send_str("+007\r");
    pin("plus007", 1, 0, 12'h007, 0, 1, 0);

    send_str("+12");
    repeat (15) @(posedge clk);
    pin("timeout_not_yet", 0, 0, 12'h007, 0, 1, 1);
    @(posedge clk);
    pin("timeout_fired", 0, 0, 12'h007, 1, 3, 0);

    send_str("+/");
    pin("below_0", 0, 0, 12'h007, 1, 1, 0);
    send_str("+0:");
    pin("above_9", 0, 0, 12'h007, 1, 1, 0);
    send_str("+-");
    pin("sign_as_digit", 0, 0, 12'h007, 1, 1, 0);
    send_str("+123x");
    pin("bad_terminator", 0, 0, 12'h007, 1, 1, 0);
    send_str(" \r\n");
    pin("idle_whitespace", 0, 0, 12'h007, 0, 1, 0);

    cmd_ready = 1'b0;
    send_str("+111\r");
    pin("plus111_held", 1, 0, 12'h111, 0, 1, 0);
    send_str("-222");
    cmd_ready = 1'b1;
    send_str("\r");
    pin("same_cycle_commit", 1, 1, 12'h222, 0, 1, 0);
    pin("same_cycle_drop", 0, 1, 12'h222, 0, 1, 0);

    send_str("+5");
    repeat (15) @(posedge clk);
    #1;
    send_str("00\r");
    pin("byte_on_timeout_cycle", 1, 0, 12'h500, 0, 1, 0);

    send_str("+4");
    pin("before_reset", 0, 0, 12'h500, 0, 1, 1);
    reset = 1'b1;
    pin("in_reset", 0, 0, 12'h000, 0, 0, 0);
    reset = 1'b0;
    #1;
    send_str("+400\r");
    pin("plus400_after_reset", 1, 0, 12'h400, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
